// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// The control unit is the master; the datapath is the slave.
interface multicycle_control_fsm_if #(
    parameter int STATE_W = 5
);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic               PCen;
    logic               IorD;
    logic               IRWrite;
    logic               MemWrite;
    logic               RegWrite;
    logic               ALUSrcA;
    logic               Ori;
    logic               ANDIsel;
    logic [1:0]         ALUSrcB;
    logic [1:0]         PCSrc;
    logic [1:0]         RegDst;
    logic [1:0]         MemtoReg;
    logic [2:0]         ALUControl;
    logic               instr_done_o;
    logic               illegal_o;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  op, funct, zero,
        output PCen, IorD, IRWrite, MemWrite, RegWrite,
        output ALUSrcA, Ori, ANDIsel,
        output ALUSrcB, PCSrc, RegDst, MemtoReg, ALUControl,
        output instr_done_o, illegal_o, state_o
    );

    modport slave (
        output op, funct, zero,
        input  PCen, IorD, IRWrite, MemWrite, RegWrite,
        input  ALUSrcA, Ori, ANDIsel,
        input  ALUSrcB, PCSrc, RegDst, MemtoReg, ALUControl,
        input  instr_done_o, illegal_o, state_o
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle MIPS core.
// Outputs decode from the registered state; PCen also sees zero in BRANCH.
module multicycle_control_fsm #(
    parameter int         STATE_W = 5,
    parameter logic [5:0] OP_IN   = 6'h3E,
    parameter logic [5:0] OP_OUT  = 6'h3F
) (
    input logic                   clk,
    input logic                   reset,
    multicycle_control_fsm_if.master bus
);
    localparam logic [STATE_W-1:0] S_RST    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_RTYPE  = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_ADDI   = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_ANDI   = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_ORI    = STATE_W'(11);
    localparam logic [STATE_W-1:0] S_IMMWB  = STATE_W'(12);
    localparam logic [STATE_W-1:0] S_GIN    = STATE_W'(13);
    localparam logic [STATE_W-1:0] S_GOUT   = STATE_W'(14);
    localparam logic [STATE_W-1:0] S_BRANCH = STATE_W'(15);
    localparam logic [STATE_W-1:0] S_JUMP   = STATE_W'(16);
    localparam logic [STATE_W-1:0] S_JAL    = STATE_W'(17);
    localparam logic [STATE_W-1:0] S_JR     = STATE_W'(18);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next;
    logic               illegal;
    logic               set_ill;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_RST;
            illegal <= 1'b0;
        end else begin
            state <= next;
            if (set_ill) illegal <= 1'b1;
        end
    end

    assign bus.illegal_o = illegal;
    assign bus.state_o   = state;

    always_comb begin
        next             = S_FETCH;
        set_ill          = 1'b0;
        bus.PCen         = 1'b0;
        bus.IorD         = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.RegWrite     = 1'b0;
        bus.ALUSrcA      = 1'b0;
        bus.Ori          = 1'b0;
        bus.ANDIsel      = 1'b0;
        bus.ALUSrcB      = 2'b00;
        bus.PCSrc        = 2'b00;
        bus.RegDst       = 2'b00;
        bus.MemtoReg     = 2'b00;
        bus.ALUControl   = ALU_AND;
        bus.instr_done_o = 1'b0;
        case (state)
            S_RST: next = S_FETCH;
            S_FETCH: begin
                bus.IRWrite    = 1'b1;
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = ALU_ADD;
                bus.PCen       = 1'b1;
                next           = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed here, ahead of knowing the op.
                bus.ALUSrcB    = 2'b11;
                bus.ALUControl = ALU_ADD;
                case (bus.op)
                    6'h23, 6'h2B: next = S_MEMADR;
                    6'h00: next = (bus.funct == 6'h08) ? S_JR : S_RTYPE;
                    6'h08: next = S_ADDI;
                    6'h0C: next = S_ANDI;
                    6'h0D: next = S_ORI;
                    6'h04, 6'h05: next = S_BRANCH;
                    6'h02: next = S_JUMP;
                    6'h03: next = S_JAL;
                    OP_IN: next = S_GIN;
                    OP_OUT: next = S_GOUT;
                    default: begin
                        set_ill          = 1'b1;
                        bus.instr_done_o = 1'b1;
                        next             = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 2'b10;
                bus.ALUControl = ALU_ADD;
                next = (bus.op == 6'h23) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.IorD = 1'b1;
                next     = S_MEMWB;
            end
            S_MEMWB: begin
                bus.IorD         = 1'b1;
                bus.MemtoReg     = 2'b01;
                bus.RegWrite     = 1'b1;
                bus.instr_done_o = 1'b1;
            end
            S_MEMWR: begin
                bus.IorD         = 1'b1;
                bus.MemWrite     = 1'b1;
                bus.instr_done_o = 1'b1;
            end
            S_RTYPE: begin
                bus.ALUSrcA = 1'b1;
                next        = S_ALUWB;
                case (bus.funct)
                    6'h20: bus.ALUControl = ALU_ADD;
                    6'h22: bus.ALUControl = ALU_SUB;
                    6'h24: bus.ALUControl = ALU_AND;
                    6'h25: bus.ALUControl = ALU_OR;
                    6'h2A: bus.ALUControl = ALU_SLT;
                    default: begin
                        bus.ALUControl   = ALU_ADD;
                        set_ill          = 1'b1;
                        bus.instr_done_o = 1'b1;
                        next             = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                bus.RegDst       = 2'b01;
                bus.RegWrite     = 1'b1;
                bus.instr_done_o = 1'b1;
            end
            S_ADDI, S_ANDI, S_ORI, S_GIN: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.Ori     = (state == S_GIN);
                bus.ALUControl = (state == S_ANDI) ? ALU_AND :
                                 (state == S_ORI)  ? ALU_OR  : ALU_ADD;
                next = S_IMMWB;
            end
            S_IMMWB: begin
                bus.RegWrite     = 1'b1;
                bus.instr_done_o = 1'b1;
            end
            S_GOUT: begin
                bus.ANDIsel      = 1'b1;
                bus.instr_done_o = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA      = 1'b1;
                bus.ALUControl   = ALU_SUB;
                bus.PCSrc        = 2'b01;
                bus.PCen = (bus.op == 6'h05) ? ~bus.zero : bus.zero;
                bus.instr_done_o = 1'b1;
            end
            S_JUMP: begin
                bus.PCSrc        = 2'b10;
                bus.PCen         = 1'b1;
                bus.instr_done_o = 1'b1;
            end
            S_JAL: begin
                // Link writes the already-incremented PC before it moves.
                bus.PCSrc        = 2'b10;
                bus.PCen         = 1'b1;
                bus.RegDst       = 2'b10;
                bus.MemtoReg     = 2'b10;
                bus.RegWrite     = 1'b1;
                bus.instr_done_o = 1'b1;
            end
            S_JR: begin
                bus.PCSrc        = 2'b11;
                bus.PCen         = 1'b1;
                bus.instr_done_o = 1'b1;
            end
            default: next = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for the multicycle control FSM.
// Walks each instruction class state by state against hand values.
module tb_multicycle_control_fsm;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    multicycle_control_fsm_if #(.STATE_W(5)) bus ();

    multicycle_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] RST = 5'd0, FETCH = 5'd1, DECODE = 5'd2;
    localparam logic [4:0] MEMADR = 5'd3, MEMRD = 5'd4, MEMWB = 5'd5;
    localparam logic [4:0] MEMWR = 5'd6, RTYPE = 5'd7, ALUWB = 5'd8;
    localparam logic [4:0] BRANCH = 5'd15, JAL = 5'd17, JR = 5'd18;

    function automatic logic [19:0] mk(
        input logic pcen, iord, irw, mw, rw, srca, ori, andi,
        input logic [1:0] srcb, pcsrc, rdst, m2r,
        input logic [2:0] alu,
        input logic done
    );
        return {pcen, iord, irw, mw, rw, srca, ori, andi,
                srcb, pcsrc, rdst, m2r, alu, done};
    endfunction

    function automatic logic [19:0] outs();
        return {bus.PCen, bus.IorD, bus.IRWrite, bus.MemWrite,
                bus.RegWrite, bus.ALUSrcA, bus.Ori, bus.ANDIsel,
                bus.ALUSrcB, bus.PCSrc, bus.RegDst, bus.MemtoReg,
                bus.ALUControl, bus.instr_done_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [4:0] st,
                        input logic [19:0] e);
        @(negedge clk);
        chk({tag, "/state"}, 32'(bus.state_o), 32'(st));
        chk({tag, "/ctl"}, 32'(outs()), 32'(e));
    endtask

    logic [19:0] e_fetch, e_dec, e_madr, e_mrd, e_mwb, e_mwr;
    logic [19:0] e_radd, e_awb, e_brt, e_brf, e_jal, e_jr, e_dill;

    initial begin
        e_fetch = mk(1,0,1,0,0,0,0,0,2'b01,2'b00,2'b00,2'b00,3'b010,0);
        e_dec   = mk(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,2'b00,3'b010,0);
        e_madr  = mk(0,0,0,0,0,1,0,0,2'b10,2'b00,2'b00,2'b00,3'b010,0);
        e_mrd   = mk(0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0);
        e_mwb   = mk(0,1,0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,1);
        e_mwr   = mk(0,1,0,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1);
        e_radd  = mk(0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b010,0);
        e_awb   = mk(0,0,0,0,1,0,0,0,2'b00,2'b00,2'b01,2'b00,3'b000,1);
        e_brt   = mk(1,0,0,0,0,1,0,0,2'b00,2'b01,2'b00,2'b00,3'b110,1);
        e_brf   = mk(0,0,0,0,0,1,0,0,2'b00,2'b01,2'b00,2'b00,3'b110,1);
        e_jal   = mk(1,0,0,0,1,0,0,0,2'b00,2'b10,2'b10,2'b10,3'b000,1);
        e_jr    = mk(1,0,0,0,0,0,0,0,2'b00,2'b11,2'b00,2'b00,3'b000,1);
        e_dill  = mk(0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,2'b00,3'b010,1);

        reset = 1'b0;
        bus.op = 6'h00;
        bus.funct = 6'h20;
        bus.zero = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst/state", 32'(bus.state_o), 32'(RST));
        chk("rst/ctl", 32'(outs()), 32'd0);
        chk("rst/ill", 32'(bus.illegal_o), 32'd0);
        reset = 1'b1;
        #1;
        chk("rel/state", 32'(bus.state_o), 32'(RST));
        chk("rel/ctl", 32'(outs()), 32'd0);

        // R-type add
        step("add/f", FETCH, e_fetch);
        bus.op = 6'h00; bus.funct = 6'h20;
        step("add/d", DECODE, e_dec);
        step("add/r", RTYPE, e_radd);
        step("add/wb", ALUWB, e_awb);

        // lw
        step("lw/f", FETCH, e_fetch);
        bus.op = 6'h23;
        step("lw/d", DECODE, e_dec);
        step("lw/a", MEMADR, e_madr);
        step("lw/rd", MEMRD, e_mrd);
        step("lw/wb", MEMWB, e_mwb);

        // sw
        step("sw/f", FETCH, e_fetch);
        bus.op = 6'h2B;
        step("sw/d", DECODE, e_dec);
        step("sw/a", MEMADR, e_madr);
        step("sw/wr", MEMWR, e_mwr);

        // beq taken, beq not taken, bne taken
        step("beq1/f", FETCH, e_fetch);
        bus.op = 6'h04; bus.zero = 1'b1;
        step("beq1/d", DECODE, e_dec);
        step("beq1/b", BRANCH, e_brt);
        step("beq0/f", FETCH, e_fetch);
        bus.zero = 1'b0;
        step("beq0/d", DECODE, e_dec);
        step("beq0/b", BRANCH, e_brf);
        step("bne/f", FETCH, e_fetch);
        bus.op = 6'h05; bus.zero = 1'b0;
        step("bne/d", DECODE, e_dec);
        step("bne/b", BRANCH, e_brt);

        // jal, jr
        step("jal/f", FETCH, e_fetch);
        bus.op = 6'h03;
        step("jal/d", DECODE, e_dec);
        step("jal/j", JAL, e_jal);
        step("jr/f", FETCH, e_fetch);
        bus.op = 6'h00; bus.funct = 6'h08;
        step("jr/d", DECODE, e_dec);
        step("jr/j", JR, e_jr);
        chk("pre/ill", 32'(bus.illegal_o), 32'd0);

        // illegal opcode, then a legal sw keeps the sticky flag
        step("ill/f", FETCH, e_fetch);
        bus.op = 6'h3A;
        step("ill/d", DECODE, e_dill);
        step("ill/f2", FETCH, e_fetch);
        chk("ill/set", 32'(bus.illegal_o), 32'd1);
        bus.op = 6'h2B;
        step("ill/d2", DECODE, e_dec);
        step("ill/a", MEMADR, e_madr);
        step("ill/wr", MEMWR, e_mwr);
        chk("ill/keep", 32'(bus.illegal_o), 32'd1);

        // asynchronous reset in the middle of MEMWR
        #2 reset = 1'b0;
        #1;
        chk("arst/state", 32'(bus.state_o), 32'(RST));
        chk("arst/mw", 32'(bus.MemWrite), 32'd0);
        chk("arst/ill", 32'(bus.illegal_o), 32'd0);
        chk("arst/ctl", 32'(outs()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step("post/f", FETCH, e_fetch);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control unit for the multicycle MIPS core.
- Consumes op, funct and zero from the datapath and drives every datapath control input (PCen, IorD, IRWrite, ALUSrcA/B, PCSrc, RegDst, MemtoReg, RegWrite, MemWrite, Ori, ANDIsel, ALUControl).
- Moore FSM. Per-state outputs are decoded combinationally from the registered state; PCen also depends on zero in BRANCH.

Parameters:
- STATE_W, 5, state register width.
- OP_IN, 6'h3E, opcode of GPIO-input instruction (rt <- rs + sext(GPIO_i)).
- OP_OUT, 6'h3F, opcode of GPIO-output instruction (rs routed to GPIO_o).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  Instr[31:26].
- funct  in  6  Instr[5:0].
- zero  in  1  ALU zero flag, combinational.
- PCen, IorD, IRWrite, MemWrite, RegWrite, ALUSrcA, Ori, ANDIsel  out  1 each  datapath controls.
- ALUSrcB, PCSrc, RegDst, MemtoReg  out  2 each  mux selects.
- ALUControl  out  3  ALU operation.
- instr_done_o  out  1  high in the last state of each instruction.
- illegal_o  out  1  sticky; set on an unknown op, or an unknown funct when op=0.
- state_o  out  STATE_W  current state, for debug.

Behaviour:
- Encodings:
  - ALUSrcB: 00=B, 01=4, 10=sext, 11=sext<<2.
  - PCSrc: 00=ALUResult, 01=ALU_o, 10=jump target, 11=regA.
  - RegDst: 00=rt, 01=rd, 10=31.
  - MemtoReg: 00=ALU_o, 01=MemOut, 10=PC.
  - ALUSrcA: 0=PC, 1=A.
  - IorD: 0=PC, 1=ALU_o.
  - ALUControl: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- Every output not listed for a state is 0.
- Reset (reset=0, asynchronous): state=RST, illegal_o=0, all outputs 0. The first edge after release goes to FETCH.
- FETCH: IRWrite=1, ALUSrcB=01, ADD, PCSrc=00, PCen=1. Next state is DECODE.
- DECODE: ALUSrcB=11, ADD (branch target into ALU_o). Next state by op:
  - 0x23 or 0x2B -> MEMADR.
  - 0x00 -> RTYPE, or JR when funct=0x08.
  - 0x08 -> ADDI; 0x0C -> ANDI; 0x0D -> ORI.
  - 0x04 or 0x05 -> BRANCH.
  - 0x02 -> JUMP; 0x03 -> JAL.
  - OP_IN -> GIN; OP_OUT -> GOUT.
  - Anything else -> FETCH, with illegal_o set and instr_done_o=1 in DECODE.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1 -> MEMWB.
- MEMWB: IorD=1, RegDst=00, MemtoReg=01, RegWrite=1, done -> FETCH.
- MEMWR: IorD=1, MemWrite=1, done -> FETCH.
- RTYPE: ALUSrcA=1, ALUSrcB=00, ALUControl from funct:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
  - Other funct: illegal_o set, ADD used, no writeback, -> FETCH with done.
  - Legal funct -> ALUWB.
- ALUWB: RegDst=01, MemtoReg=00, RegWrite=1, done -> FETCH.
- ADDI/ANDI/ORI: ALUSrcA=1, ALUSrcB=10, ADD/AND/OR respectively, -> IMMWB. The immediate is sign-extended for all three.
- IMMWB: RegDst=00, MemtoReg=00, RegWrite=1, done -> FETCH.
- GIN: ALUSrcA=1, ALUSrcB=10, Ori=1, ADD -> IMMWB.
- GOUT: ANDIsel=1, done -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, done -> FETCH.
  - PCen=zero for op 0x04; PCen=~zero for op 0x05.
  - PCen is combinational in this state.
- JUMP: PCSrc=10, PCen=1, done -> FETCH.
- JAL: PCSrc=10, PCen=1, RegDst=10, MemtoReg=10, RegWrite=1, done -> FETCH. PC is already PC+4 and is sampled before the same edge updates it.
- JR: PCSrc=11, PCen=1, done -> FETCH.
- Latency in cycles, FETCH to done inclusive:
  - lw 5.
  - sw, R-type, addi, andi, ori, GIN 4.
  - beq, bne, j, jal, jr, GOUT 3.
  - illegal 2.
- Sampling rules:
  - op and funct are sampled only in DECODE and the decode-dependent states; they are stable because IRWrite=0 there.
  - zero is used only in BRANCH.
- Reset mid-instruction: immediate return to RST with outputs 0. MemWrite and RegWrite drop asynchronously.
- illegal_o is cleared only by reset.
- Unused state codes go to FETCH on the next edge with all outputs 0.

Test Plan:
- Reset sequence: hold reset=0 for 3 cycles then release -> RST with all outputs 0, then FETCH: IRWrite=1, PCen=1, ALUSrcB=01, ALUControl=010.
- Type-R add (op=0, funct=0x20) -> FETCH, DECODE, RTYPE (ALUControl=010, ALUSrcA=1), ALUWB (RegWrite=1, RegDst=01); instr_done_o only in ALUWB; 4 cycles.
- lw (op=0x23) -> MEMADR, MEMRD, MEMWB with IorD=1 in the last two and MemtoReg=01, RegWrite=1; sw (0x2B) -> MEMWR with MemWrite=1, RegWrite=0.
- beq (op=0x04) with zero=1 -> PCen=1, PCSrc=01 in BRANCH; zero=0 -> PCen=0; bne (0x05) with zero=0 -> PCen=1.
- jal (op=0x03) -> JAL with PCSrc=10, RegDst=10, MemtoReg=10, RegWrite=1, PCen=1; jr (op=0, funct=0x08) -> PCSrc=11, PCen=1.
- Error paths:
  - op=0x3A -> illegal_o=1 persists across the next legal instruction.
  - Reset asserted during MEMWR -> MemWrite=0 immediately, illegal_o=0, state_o=RST.
